// File: rtl/uart_msg_seq.sv
// ROM-driven message sequencer: streams a length-prefixed byte string from one ROM slot
// into the UART write port. Define UART_MSG_SEQ_ERR_ABORT_EN to abort a message on wr_err_i.
module uart_msg_seq #(
    parameter int          NUM_MSG      = 4,
    parameter int          SLOT_W       = 4,
    parameter logic [3:0]  UART_TX_ADDR = 4'd4
) (
    input  logic                               clk_i,
    input  logic                               rst_n_i,
    input  logic                               start_i,
    input  logic [$clog2(NUM_MSG)-1:0]         msg_sel_i,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               err_o,
    output logic [$clog2(NUM_MSG)+SLOT_W-1:0]  rom_addr_o,
    input  logic [7:0]                         rom_data_i,
    output logic                               wr_valid_o,
    output logic [7:0]                         wr_data_o,
    output logic [3:0]                         wr_addr_o,
    input  logic                               wr_ready_i,
    input  logic                               wr_err_i
);
    localparam int         SEL_W   = $clog2(NUM_MSG);
    localparam logic [7:0] MAX_LEN = 8'((1 << SLOT_W) - 1);

    typedef enum logic [2:0] {IDLE, HDR, LEN, FETCH, LOAD, SEND, DONE} state_t;

    state_t            state;
    logic [SEL_W-1:0]  slot_q;
    logic [SLOT_W-1:0] off_q;
    logic [SLOT_W-1:0] rem_q;
    logic [SLOT_W-1:0] len_clamped;
    logic              abort;

    // Length byte is compared on all 8 bits before truncation to the slot size.
    always_comb begin
        len_clamped = rom_data_i[SLOT_W-1:0];
        if (rom_data_i > MAX_LEN) len_clamped = MAX_LEN[SLOT_W-1:0];
    end

`ifdef UART_MSG_SEQ_ERR_ABORT_EN
    assign abort = wr_err_i;
`else
    logic unused_err;
    assign unused_err = wr_err_i;
    assign abort      = 1'b0;
    assign err_o      = 1'b0;
`endif

    assign rom_addr_o = {slot_q, off_q};
    assign wr_addr_o  = UART_TX_ADDR;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            slot_q     <= '0;
            off_q      <= '0;
            rem_q      <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            wr_valid_o <= 1'b0;
            wr_data_o  <= '0;
`ifdef UART_MSG_SEQ_ERR_ABORT_EN
            err_o      <= 1'b0;
`endif
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: if (start_i) begin
                    slot_q <= msg_sel_i;
                    off_q  <= '0;
                    busy_o <= 1'b1;
`ifdef UART_MSG_SEQ_ERR_ABORT_EN
                    err_o  <= 1'b0;
`endif
                    state  <= HDR;
                end
                HDR: state <= LEN;
                LEN: begin
                    rem_q <= len_clamped;
                    if (len_clamped == '0) begin
                        done_o <= 1'b1;
                        state  <= DONE;
                    end else begin
                        off_q <= off_q + SLOT_W'(1);
                        state <= FETCH;
                    end
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    wr_data_o  <= rom_data_i;
                    wr_valid_o <= 1'b1;
                    state      <= SEND;
                end
                SEND: if (wr_ready_i) begin
                    wr_valid_o <= 1'b0;
                    rem_q      <= rem_q - SLOT_W'(1);
                    // Offset wraps inside the slot; the slot field never carries.
                    off_q      <= off_q + SLOT_W'(1);
`ifdef UART_MSG_SEQ_ERR_ABORT_EN
                    if (wr_err_i) err_o <= 1'b1;
`endif
                    if (abort || rem_q == SLOT_W'(1)) begin
                        done_o <= 1'b1;
                        state  <= DONE;
                    end else begin
                        state <= FETCH;
                    end
                end
                DONE: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_msg_seq.sv
// Scoreboard bench for uart_msg_seq: expected (address, byte) pairs are queued from the
// bench's own ROM image at start and popped on every observed UART transfer.
module tb_uart_msg_seq;
    localparam int NUM_MSG = 4;
    localparam int SLOT_W  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] msel = '0;
    logic       busy, done, err;
    logic [5:0] rom_addr;
    logic [7:0] rom_data;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic [3:0] wr_addr;
    logic       wr_ready = 1'b1;
    logic       wr_err = 1'b0;

    uart_msg_seq #(.NUM_MSG(NUM_MSG), .SLOT_W(SLOT_W), .UART_TX_ADDR(4'd4)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .msg_sel_i(msel),
        .busy_o(busy), .done_o(done), .err_o(err),
        .rom_addr_o(rom_addr), .rom_data_i(rom_data),
        .wr_valid_o(wr_valid), .wr_data_o(wr_data), .wr_addr_o(wr_addr),
        .wr_ready_i(wr_ready), .wr_err_i(wr_err)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:63];
    always @(posedge clk) rom_data <= mem[rom_addr];

    typedef struct packed {
        logic [5:0] addr;
        logic [7:0] data;
    } xfer_t;

    xfer_t exp_q[$];
    int passed = 0;
    int total  = 0;

    task automatic push_msg(input logic [1:0] sel, input int max_bytes);
        int n;
        logic [5:0] a;
        n = int'(mem[{sel, 4'h0}]);
        if (n > 15) n = 15;
        if (max_bytes < n) n = max_bytes;
        for (int i = 1; i <= n; i++) begin
            a = {sel, 4'(i)};
            exp_q.push_back('{addr: a, data: mem[a]});
        end
    endtask

    // Caller is at a negedge. Cycle c is the interval between edge c-1 and edge c,
    // edge 0 being the edge that accepts start.
    task automatic run_msg(input string name, input logic [1:0] sel, input int stall_byte,
                           input int stall_cyc, input int err_byte,
                           output int first_vld, output int done_cyc, output int nxfer);
        int stall_left;
        bit held, stable;
        logic [7:0] held_data;
        xfer_t e;
        first_vld = 0; done_cyc = 0; nxfer = 0;
        stall_left = stall_cyc; held = 0; stable = 1; held_data = '0;
        msel = sel; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 200 && done_cyc == 0; c++) begin
            @(negedge clk);
            start = 1'b0; wr_ready = 1'b1; wr_err = 1'b0;
            if (held && !(wr_valid === 1'b1 && wr_data === held_data)) stable = 0;
            held = 0;
            if (done === 1'b1) done_cyc = c;
            if (wr_valid === 1'b1) begin
                if (first_vld == 0) first_vld = c;
                if (nxfer + 1 == stall_byte && stall_left > 0) begin
                    wr_ready = 1'b0; stall_left--; held = 1; held_data = wr_data;
                    start = 1'b1;  // must be ignored while busy
                end else begin
                    wr_err = (nxfer + 1 == err_byte);
                    total++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL %s unexpected transfer addr=%h data=%h", name, rom_addr, wr_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (wr_data !== e.data || rom_addr !== e.addr)
                            $display("FAIL %s byte%0d got addr=%h data=%h want addr=%h data=%h",
                                     name, nxfer + 1, rom_addr, wr_data, e.addr, e.data);
                        else passed++;
                    end
                    nxfer++;
                end
            end
        end
        total++;
        if (done_cyc == 0) $display("FAIL %s timeout waiting for done_o", name);
        else passed++;
        @(negedge clk);
        wr_err = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL %s after done busy=%b done=%b want 0 0", name, busy, done);
        else passed++;
        if (stall_cyc > 0) begin
            total++;
            if (!stable) $display("FAIL %s stall stability lost", name);
            else passed++;
        end
        total++;
        if (exp_q.size() != 0) $display("FAIL %s missing bytes got %0d left want 0", name, exp_q.size());
        else passed++;
        exp_q.delete();
    endtask

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got !== want) $display("FAIL %s got %0d want %0d", name, got, want);
        else passed++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b1; msel = 2'd1;
        repeat (3) @(negedge clk);
        total++;
        if (wr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0)
            $display("FAIL reset_flags got v=%b b=%b d=%b e=%b want 0", wr_valid, busy, done, err);
        else passed++;
        total++;
        if (rom_addr !== 6'd0 || wr_data !== 8'd0)
            $display("FAIL reset_regs got addr=%h data=%h want 0", rom_addr, wr_data);
        else passed++;
        total++;
        if (wr_addr !== 4'd4) $display("FAIL reset_wr_addr got %h want 4", wr_addr);
        else passed++;
        start = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) $display("FAIL reset_idle busy=%b want 0", busy);
        else passed++;
    endtask

    task automatic test_basic;
        int fv, dc, nx;
        push_msg(2'd1, 99);
        run_msg("basic", 2'd1, 0, 0, 0, fv, dc, nx);
        chk("basic_first_valid", fv, 5);
        chk("basic_done_cycle", dc, 12);
        chk("basic_count", nx, 3);
    endtask

    task automatic test_empty;
        int fv, dc, nx;
        push_msg(2'd2, 99);
        run_msg("empty", 2'd2, 0, 0, 0, fv, dc, nx);
        chk("empty_no_valid", fv, 0);
        chk("empty_done_cycle", dc, 3);
    endtask

    task automatic test_clamp;
        int fv, dc, nx;
        push_msg(2'd3, 99);
        run_msg("clamp", 2'd3, 0, 0, 0, fv, dc, nx);
        chk("clamp_count", nx, 15);
        chk("clamp_done_cycle", dc, 48);
    endtask

    task automatic test_backpressure;
        int fv, dc, nx;
        push_msg(2'd1, 99);
        run_msg("backpressure", 2'd1, 2, 10, 0, fv, dc, nx);
        chk("bp_count", nx, 3);
        chk("bp_done_cycle", dc, 22);
    endtask

    task automatic test_error;
        int fv, dc, nx;
`ifdef UART_MSG_SEQ_ERR_ABORT_EN
        push_msg(2'd0, 1);
        run_msg("error", 2'd0, 0, 0, 1, fv, dc, nx);
        chk("err_count", nx, 1);
        chk("err_done_cycle", dc, 6);
        chk("err_sticky", int'(err), 1);
`else
        push_msg(2'd0, 99);
        run_msg("error", 2'd0, 0, 0, 1, fv, dc, nx);
        chk("err_count", nx, 4);
        chk("err_done_cycle", dc, 15);
        chk("err_flag", int'(err), 0);
`endif
        push_msg(2'd1, 99);
        run_msg("after_err", 2'd1, 0, 0, 0, fv, dc, nx);
        chk("err_cleared", int'(err), 0);
    endtask

    task automatic test_async_reset;
        int fv, dc, nx;
        bit seen;
        seen = 0;
        msel = 2'd1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; wr_ready = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (wr_valid === 1'b1) seen = 1;
        end
        chk("arst_reached_send", int'(seen), 1);
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (wr_valid !== 1'b0 || busy !== 1'b0 || rom_addr !== 6'd0)
            $display("FAIL arst_immediate got v=%b b=%b addr=%h want 0", wr_valid, busy, rom_addr);
        else passed++;
        @(negedge clk); rst_n = 1'b1; wr_ready = 1'b1;
        @(negedge clk);
        push_msg(2'd1, 99);
        run_msg("arst_resend", 2'd1, 0, 0, 0, fv, dc, nx);
        chk("arst_count", nx, 3);
        chk("arst_done_cycle", dc, 12);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'hEE;
        mem[6'h00] = 8'd4;
        for (int i = 1; i <= 4; i++) mem[i] = 8'h10 + 8'(i);
        mem[6'h10] = 8'd3;
        mem[6'h11] = 8'h41; mem[6'h12] = 8'h42; mem[6'h13] = 8'h43;
        mem[6'h20] = 8'd0;
        mem[6'h30] = 8'hFF;
        for (int i = 1; i <= 15; i++) mem[6'h30 + i] = 8'h50 + 8'(i);

        test_reset();
        test_basic();
        test_empty();
        test_clamp();
        test_backpressure();
        test_error();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
